iccm_sram_ctrl: RTL

Parametrised controller between the instruction-memory host request port (req/gnt/rvalid, as driven by the TL-UL SRAM adapter) and a single-port SRAM macro with active-low chip-select and write-enable. Adds a streaming programming channel with auto-incrementing address, a running checksum and overflow/abort error reporting. A configurable-latency read-valid pipeline and a programming FSM arbitrate the macro, so boot loading never corrupts in-flight host reads.

---
 rtl/iccm_pkg.sv | 26 ++
 rtl/iccm_rvalid_pipe.sv | 45 ++++
 rtl/iccm_sram_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/iccm_pkg.sv
// -----------------------------------------------------------------------------
// iccm_pkg
// Shared definitions for the instruction-memory SRAM controller:
//   - prog_state_e : programming FSM state encoding
//   - READ_LAT_MIN / READ_LAT_MAX : supported macro read-latency range
//   - byte_enable() : collapses an 8-bit slice of a bit-granular write mask
//                     into the single byte-enable the macro understands
// -----------------------------------------------------------------------------
package iccm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PROG  = 2'd2,
    ST_DONE  = 2'd3
  } prog_state_e;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 3;

  // A byte is written if any bit of it is enabled in the host mask.
  function automatic logic byte_enable(input logic [7:0] bit_mask);
    return |bit_mask;
  endfunction

endpackage

// File: rtl/iccm_rvalid_pipe.sv
// -----------------------------------------------------------------------------
// iccm_rvalid_pipe
// LAT-stage shift register carrying one flag per granted host read. The last
// stage is the read-valid for the data the macro returns this cycle.
//   clk_i, rst_i : clock, asynchronous active-high reset (clears all stages)
//   push_i       : a read was granted this cycle
//   valid_o      : read data from the macro is valid this cycle
//   empty_o      : no read is outstanding beyond the one (if any) completing
//                  this cycle, so the macro may be handed over next cycle
// -----------------------------------------------------------------------------
module iccm_rvalid_pipe #(
  parameter int unsigned LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  output logic valid_o,
  output logic empty_o
);

  logic [LAT-1:0] stage_q;
  logic [LAT-1:0] stage_d;

  generate
    if (LAT == 1) begin : g_one
      assign stage_d = push_i;
      // The only stage is the one completing now.
      assign empty_o = 1'b1;
    end else begin : g_multi
      assign stage_d = {stage_q[LAT-2:0], push_i};
      assign empty_o = ~|stage_q[LAT-2:0];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_o = stage_q[LAT-1];

endmodule

// File: rtl/iccm_sram_ctrl.sv
// -----------------------------------------------------------------------------
// iccm_sram_ctrl
// Arbitrates a single-port SRAM macro between the host request port and a
// streaming programming channel.
//
// Handshakes:
//   host : a request is accepted in the cycle host_req_i & host_gnt_o; the
//          macro is driven combinationally in that same cycle. Reads return
//          host_rvalid_o/host_rdata_o exactly READ_LAT cycles later.
//   prog : a word transfers in the cycle prog_valid_i & prog_ready_o; valid
//          may be held without ready, data/last are sampled only on transfer.
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   host_req/gnt/we/addr/wdata/wmask  host request channel
//   host_rvalid_o, host_rdata_o       host read response
//   prog_start_i, prog_base_i         open a programming session at a base
//   prog_valid/ready/data/last        programming word stream
//   prog_abort_i                      abandon the session (sets error)
//   prog_busy/done/err/count/sum      session status
//   csb_o, web_o, addr_o, wdata_o,
//   wmask_o, rdata_i                  SRAM macro port (active-low controls)
// -----------------------------------------------------------------------------
module iccm_sram_ctrl
  import iccm_pkg::*;
#(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            host_req_i,
  output logic            host_gnt_o,
  input  logic            host_we_i,
  input  logic [AW-1:0]   host_addr_i,
  input  logic [DW-1:0]   host_wdata_i,
  input  logic [DW-1:0]   host_wmask_i,
  output logic            host_rvalid_o,
  output logic [DW-1:0]   host_rdata_o,
  input  logic            prog_start_i,
  input  logic [AW-1:0]   prog_base_i,
  input  logic            prog_valid_i,
  output logic            prog_ready_o,
  input  logic [DW-1:0]   prog_data_i,
  input  logic            prog_last_i,
  input  logic            prog_abort_i,
  output logic            prog_busy_o,
  output logic            prog_done_o,
  output logic            prog_err_o,
  output logic [AW:0]     prog_count_o,
  output logic [DW-1:0]   prog_sum_o,
  output logic            csb_o,
  output logic            web_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] wmask_o,
  input  logic [DW-1:0]   rdata_i
);

  localparam int unsigned NB = DW / 8;
  // Out-of-range latencies are pulled into the supported window.
  localparam int unsigned LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                                (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  prog_state_e state_q, state_d;

  // One extra bit: the MSB flags that the session ran past DEPTH-1.
  logic [AW:0]   addr_cnt_q, addr_cnt_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          err_q, err_d;

  logic          host_rd_fire;
  logic          pipe_valid;
  logic          pipe_empty;
  logic [NB-1:0] host_bmask;

  generate
    for (genvar b = 0; b < NB; b++) begin : g_bmask
      assign host_bmask[b] = byte_enable(host_wmask_i[8*b +: 8]);
    end
  endgenerate

  iccm_rvalid_pipe #(
    .LAT (LAT)
  ) u_rvalid_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (host_rd_fire),
    .valid_o (pipe_valid),
    .empty_o (pipe_empty)
  );

  // Next-state, session bookkeeping and macro drive.
  always_comb begin
    state_d      = state_q;
    addr_cnt_d   = addr_cnt_q;
    count_d      = count_q;
    sum_d        = sum_q;
    err_d        = err_q;
    host_gnt_o   = 1'b0;
    host_rd_fire = 1'b0;
    prog_ready_o = 1'b0;
    csb_o        = 1'b1;
    web_o        = 1'b1;
    addr_o       = '0;
    wdata_o      = '0;
    wmask_o      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (prog_start_i) begin
          // Start wins over a same-cycle host request.
          state_d    = ST_DRAIN;
          addr_cnt_d = {1'b0, prog_base_i};
          count_d    = '0;
          sum_d      = '0;
          err_d      = 1'b0;
        end else if (host_req_i && !rst_i) begin
          // Gated by reset so the macro stays idle while rst_i is high.
          host_gnt_o   = 1'b1;
          host_rd_fire = ~host_we_i;
          csb_o        = 1'b0;
          web_o        = ~host_we_i;
          addr_o       = host_addr_i;
          wdata_o      = host_wdata_i;
          wmask_o      = host_bmask;
        end
      end

      ST_DRAIN: begin
        if (prog_abort_i) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (pipe_empty) begin
          state_d = ST_PROG;
        end
      end

      ST_PROG: begin
        prog_ready_o = 1'b1;
        if (prog_abort_i) begin
          // Abort overrides any handshake in the same cycle.
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (prog_valid_i) begin
          if (addr_cnt_q[AW]) begin
            // Address space exhausted: drop the word and end the session.
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            csb_o      = 1'b0;
            web_o      = 1'b0;
            addr_o     = addr_cnt_q[AW-1:0];
            wdata_o    = prog_data_i;
            wmask_o    = '1;
            addr_cnt_d = addr_cnt_q + 1'b1;
            count_d    = count_q + 1'b1;
            sum_d      = sum_q + prog_data_i;
            if (prog_last_i) begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_cnt_q <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
    end
  end

  assign host_rvalid_o = pipe_valid;
  assign host_rdata_o  = pipe_valid ? rdata_i : '0;
  assign prog_busy_o   = (state_q != ST_IDLE);
  assign prog_done_o   = (state_q == ST_DONE);
  assign prog_err_o    = err_q;
  assign prog_count_o  = count_q;
  assign prog_sum_o    = sum_q;

endmodule
